// File: rtl/amstrad_mem_pkg.sv
// Shared memory-side types for the Amstrad SDRAM port and its requesters.
package amstrad_mem_pkg;

   localparam int unsigned AW_DEFAULT = 23;

   // Slot owner, encoded exactly as driven on the owner port.
   typedef enum logic [1:0] {
      OWN_IDLE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_LD   = 2'd2,
      OWN_DMA  = 2'd3
   } owner_t;

endpackage

// File: rtl/sdram_slot_arbiter.sv
// Slot arbiter sharing the CPU-side SDRAM port between the Z80 bus, the
// download loader and the DMA engine; one owner per clkref slot.
module sdram_slot_arbiter
   import amstrad_mem_pkg::*;
#(
   parameter int unsigned AW     = AW_DEFAULT,
   parameter int unsigned RD_LAT = 8
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic          clkref,
   input  logic          hold_cpu,

   input  logic          cpu_rd,
   input  logic          cpu_wr,
   input  logic [AW-1:0] cpu_addr,
   input  logic [1:0]    cpu_bank,
   input  logic [7:0]    cpu_din,
   output logic [7:0]    cpu_dout,

   input  logic          ld_req,
   input  logic [AW-1:0] ld_addr,
   input  logic [1:0]    ld_bank,
   input  logic [7:0]    ld_din,
   output logic          ld_ack,

   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [1:0]    dma_bank,
   input  logic [7:0]    dma_din,
   output logic          dma_ack,
   output logic [7:0]    dma_dout,
   output logic          dma_valid,

   output logic          sd_oe,
   output logic          sd_we,
   output logic [AW-1:0] sd_addr,
   output logic [1:0]    sd_bank,
   output logic [7:0]    sd_din,
   input  logic [7:0]    sd_dout,

   output logic [1:0]    owner
);

   localparam int unsigned CW = $clog2(RD_LAT + 1);

   owner_t        owner_q;
   owner_t        last_low;
   logic [CW-1:0] rd_cnt;
   logic          rd_dma;
   logic          cpu_go_c;
   owner_t        low_pick_c;

   // Round-robin between loader and DMA: on a tie the one not granted last wins.
   function automatic owner_t pick_low(input logic ld, input logic dma, input owner_t last);
      owner_t pick;
      pick = OWN_IDLE;
      if (ld && dma)
         pick = (last == OWN_LD) ? OWN_DMA : OWN_LD;
      else if (ld)
         pick = OWN_LD;
      else if (dma)
         pick = OWN_DMA;
      return pick;
   endfunction

   assign cpu_go_c   = ~hold_cpu & (cpu_rd | cpu_wr);
   assign low_pick_c = pick_low(ld_req, dma_req, last_low);
   assign owner      = owner_q;

   // Slot grant, command registers, acknowledges and delayed read capture.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         owner_q   <= OWN_IDLE;
         last_low  <= OWN_DMA;
         rd_cnt    <= '0;
         rd_dma    <= 1'b0;
         sd_oe     <= 1'b0;
         sd_we     <= 1'b0;
         sd_addr   <= '0;
         sd_bank   <= 2'd0;
         sd_din    <= 8'd0;
         ld_ack    <= 1'b0;
         dma_ack   <= 1'b0;
         dma_valid <= 1'b0;
         cpu_dout  <= 8'hFF;
         dma_dout  <= 8'hFF;
      end else begin
         ld_ack    <= 1'b0;
         dma_ack   <= 1'b0;
         dma_valid <= 1'b0;

         // Count down from the grant edge; capture on the RD_LAT-th edge after it.
         if (rd_cnt != '0) begin
            rd_cnt <= rd_cnt - CW'(1);
            if (rd_cnt == CW'(1)) begin
               if (rd_dma) begin
                  dma_dout  <= sd_dout;
                  dma_valid <= 1'b1;
               end else begin
                  cpu_dout <= sd_dout;
               end
            end
         end

         if (clkref) begin
            if (cpu_go_c) begin
               // CPU write wins over a simultaneous CPU read.
               owner_q <= OWN_CPU;
               sd_we   <= cpu_wr;
               sd_oe   <= ~cpu_wr;
               sd_addr <= cpu_addr;
               sd_bank <= cpu_bank;
               sd_din  <= cpu_din;
               if (!cpu_wr) begin
                  rd_cnt <= CW'(RD_LAT);
                  rd_dma <= 1'b0;
               end
            end else begin
               owner_q <= low_pick_c;
               case (low_pick_c)
                  OWN_LD: begin
                     sd_we    <= 1'b1;
                     sd_oe    <= 1'b0;
                     sd_addr  <= ld_addr;
                     sd_bank  <= ld_bank;
                     sd_din   <= ld_din;
                     ld_ack   <= 1'b1;
                     last_low <= OWN_LD;
                  end
                  OWN_DMA: begin
                     sd_we    <= dma_we;
                     sd_oe    <= ~dma_we;
                     sd_addr  <= dma_addr;
                     sd_bank  <= dma_bank;
                     sd_din   <= dma_din;
                     dma_ack  <= 1'b1;
                     last_low <= OWN_DMA;
                     if (!dma_we) begin
                        rd_cnt <= CW'(RD_LAT);
                        rd_dma <= 1'b1;
                     end
                  end
                  default: begin
                     sd_we <= 1'b0;
                     sd_oe <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// Self-checking bench for sdram_slot_arbiter: scenario tasks plus a DMA read scoreboard.
module tb_sdram_slot_arbiter;
   import amstrad_mem_pkg::*;

   localparam int unsigned AW       = 23;
   localparam int unsigned RD_LAT   = 8;
   localparam int unsigned SLOT_GAP = RD_LAT + 2;

   logic          clk_sys = 1'b0;
   logic          reset = 1'b1;
   logic          clkref = 1'b0;
   logic          hold_cpu = 1'b0;
   logic          cpu_rd = 1'b0, cpu_wr = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [1:0]    cpu_bank = 2'd0;
   logic [7:0]    cpu_din = 8'd0;
   logic [7:0]    cpu_dout;
   logic          ld_req = 1'b0;
   logic [AW-1:0] ld_addr = '0;
   logic [1:0]    ld_bank = 2'd0;
   logic [7:0]    ld_din = 8'd0;
   logic          ld_ack;
   logic          dma_req = 1'b0, dma_we = 1'b0;
   logic [AW-1:0] dma_addr = '0;
   logic [1:0]    dma_bank = 2'd0;
   logic [7:0]    dma_din = 8'd0;
   logic          dma_ack;
   logic [7:0]    dma_dout;
   logic          dma_valid;
   logic          sd_oe, sd_we;
   logic [AW-1:0] sd_addr;
   logic [1:0]    sd_bank;
   logic [7:0]    sd_din;
   logic [7:0]    sd_dout = 8'hEE;
   logic [1:0]    owner;

   int checks = 0;
   int failures = 0;
   int ld_ack_cnt = 0;
   int dma_ack_cnt = 0;
   int dma_valid_cnt = 0;
   logic [7:0] exp_dma_q[$];
   logic [7:0] got_dma_q[$];

   sdram_slot_arbiter #(.AW(AW), .RD_LAT(RD_LAT)) dut (
      .clk_sys(clk_sys), .reset(reset), .clkref(clkref), .hold_cpu(hold_cpu),
      .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_bank(cpu_bank),
      .cpu_din(cpu_din), .cpu_dout(cpu_dout),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_bank(ld_bank), .ld_din(ld_din), .ld_ack(ld_ack),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_bank(dma_bank),
      .dma_din(dma_din), .dma_ack(dma_ack), .dma_dout(dma_dout), .dma_valid(dma_valid),
      .sd_oe(sd_oe), .sd_we(sd_we), .sd_addr(sd_addr), .sd_bank(sd_bank), .sd_din(sd_din),
      .sd_dout(sd_dout), .owner(owner)
   );

   always #5 clk_sys = ~clk_sys;

   // Pulse counters and DMA read capture, sampled shortly after each rising edge.
   always begin
      @(posedge clk_sys);
      #2;
      if (ld_ack === 1'b1) ld_ack_cnt++;
      if (dma_ack === 1'b1) dma_ack_cnt++;
      if (dma_valid === 1'b1) begin
         dma_valid_cnt++;
         got_dma_q.push_back(dma_dout);
      end
   end

   // The read latency must fit inside a slot.
   int cyc = 0;
   int last_ref = -1000;
   always @(posedge clk_sys) begin
      if (clkref) begin
         assert (cyc - last_ref >= int'(SLOT_GAP))
            else $error("clkref period %0d below RD_LAT+2", cyc - last_ref);
         last_ref = cyc;
      end
      cyc++;
   end

   initial begin
      #400000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   // Raise clkref for one edge; returns half a cycle after the grant edge T.
   task automatic slot_open();
      @(negedge clk_sys);
      clkref = 1'b1;
      @(negedge clk_sys);
      clkref = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk_sys);
      reset = 1'b1;
      wait_neg(2);
      reset = 1'b0;
      @(negedge clk_sys);
   endtask

   // Rest of a DMA read slot: present data at edge T+RD_LAT only.
   task automatic dma_slot_body(input logic [7:0] data);
      wait_neg(RD_LAT - 1);
      sd_dout = data;
      exp_dma_q.push_back(data);
      wait_neg(1);
      sd_dout = 8'hEE;
      wait_neg(3);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      wait_neg(2);
      checks++; if (owner !== 2'd0) begin failures++; $display("FAIL reset_owner got=%0d exp=0", owner); end
      checks++; if ({sd_oe, sd_we, ld_ack, dma_ack, dma_valid} !== 5'b0) begin
         failures++; $display("FAIL reset_strobes got=%b exp=00000", {sd_oe, sd_we, ld_ack, dma_ack, dma_valid}); end
      checks++; if (cpu_dout !== 8'hFF || dma_dout !== 8'hFF) begin
         failures++; $display("FAIL reset_dout got=%h/%h exp=ff/ff", cpu_dout, dma_dout); end
      checks++; if (sd_addr !== 23'd0 || sd_bank !== 2'd0 || sd_din !== 8'd0) begin
         failures++; $display("FAIL reset_cmd got=%h/%0d/%h exp=0/0/0", sd_addr, sd_bank, sd_din); end
      reset = 1'b0;
      wait_neg(1);
   endtask

   task automatic test_cpu_read();
      cpu_rd = 1'b1; cpu_addr = 23'h00123; cpu_bank = 2'd1;
      slot_open();
      checks++; if (owner !== 2'd1) begin failures++; $display("FAIL cpu_rd_owner got=%0d exp=1", owner); end
      checks++; if (sd_oe !== 1'b1 || sd_we !== 1'b0) begin
         failures++; $display("FAIL cpu_rd_en got=oe%b we%b exp=oe1 we0", sd_oe, sd_we); end
      checks++; if (sd_addr !== 23'h00123 || sd_bank !== 2'd1) begin
         failures++; $display("FAIL cpu_rd_addr got=%h/%0d exp=00123/1", sd_addr, sd_bank); end
      cpu_rd = 1'b0; cpu_addr = 23'h0ABCD;
      wait_neg(2);
      checks++; if (sd_addr !== 23'h00123 || sd_oe !== 1'b1) begin
         failures++; $display("FAIL cpu_rd_hold got=%h oe%b exp=00123 oe1", sd_addr, sd_oe); end
      wait_neg(RD_LAT - 3);
      checks++; if (cpu_dout !== 8'hFF) begin failures++; $display("FAIL cpu_rd_early got=%h exp=ff", cpu_dout); end
      sd_dout = 8'h5A;
      wait_neg(1);
      sd_dout = 8'hEE;
      checks++; if (cpu_dout !== 8'h5A) begin failures++; $display("FAIL cpu_rd_data got=%h exp=5a", cpu_dout); end
      wait_neg(3);
   endtask

   task automatic test_hold_rr();
      owner_t exp_own[3];
      owner_t e;
      logic [AW-1:0] e_addr;
      int la, da;
      exp_own[0] = OWN_LD; exp_own[1] = OWN_DMA; exp_own[2] = OWN_LD;
      apply_reset();
      hold_cpu = 1'b1; cpu_rd = 1'b1; ld_req = 1'b1; dma_req = 1'b1; dma_we = 1'b1;
      ld_addr = 23'h000100; ld_din = 8'hA1; dma_addr = 23'h000200; dma_din = 8'hD1;
      for (int s = 0; s < 3; s++) begin
         e = exp_own[s];
         e_addr = (e == OWN_LD) ? ld_addr : dma_addr;
         la = ld_ack_cnt; da = dma_ack_cnt;
         slot_open();
         checks++; if (owner !== e) begin failures++; $display("FAIL rr_owner slot%0d got=%0d exp=%0d", s, owner, e); end
         checks++; if (sd_we !== 1'b1 || sd_oe !== 1'b0 || sd_addr !== e_addr) begin
            failures++; $display("FAIL rr_cmd slot%0d got=we%b oe%b %h exp=we1 oe0 %h", s, sd_we, sd_oe, sd_addr, e_addr); end
         ld_addr = ld_addr + 23'd1; dma_addr = dma_addr + 23'd1;
         wait_neg(10);
         checks++; if (ld_ack_cnt - la !== ((e == OWN_LD) ? 1 : 0) || dma_ack_cnt - da !== ((e == OWN_DMA) ? 1 : 0)) begin
            failures++; $display("FAIL rr_acks slot%0d got=ld%0d dma%0d exp_owner=%0d", s, ld_ack_cnt - la, dma_ack_cnt - da, e); end
      end
      hold_cpu = 1'b0; cpu_rd = 1'b0; ld_req = 1'b0; dma_req = 1'b0; dma_we = 1'b0;
   endtask

   task automatic test_cpu_then_dma();
      int da;
      logic [7:0] e, g;
      da = dma_ack_cnt;
      cpu_wr = 1'b1; cpu_addr = 23'h000400; cpu_din = 8'h77;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 23'h000500; dma_bank = 2'd1;
      slot_open();
      checks++; if (owner !== 2'd1 || sd_we !== 1'b1 || sd_oe !== 1'b0) begin
         failures++; $display("FAIL cw_cpu got=own%0d we%b oe%b exp=own1 we1 oe0", owner, sd_we, sd_oe); end
      checks++; if (sd_din !== 8'h77 || sd_addr !== 23'h000400) begin
         failures++; $display("FAIL cw_cpu_cmd got=%h/%h exp=77/000400", sd_din, sd_addr); end
      cpu_wr = 1'b0;
      wait_neg(10);
      checks++; if (dma_ack_cnt !== da) begin failures++; $display("FAIL cw_early_ack got=%0d exp=0", dma_ack_cnt - da); end
      slot_open();
      checks++; if (owner !== 2'd3 || dma_ack !== 1'b1 || sd_oe !== 1'b1 || sd_addr !== 23'h000500) begin
         failures++; $display("FAIL cw_dma got=own%0d ack%b oe%b %h exp=own3 ack1 oe1 000500", owner, dma_ack, sd_oe, sd_addr); end
      dma_req = 1'b0;
      dma_slot_body(8'h3C);
      checks++; if (dma_ack_cnt - da !== 1) begin failures++; $display("FAIL cw_ack_count got=%0d exp=1", dma_ack_cnt - da); end
      checks++; if (got_dma_q.size() !== exp_dma_q.size()) begin
         failures++; $display("FAIL cw_sb_size got=%0d exp=%0d", got_dma_q.size(), exp_dma_q.size()); end
      while (exp_dma_q.size() > 0 && got_dma_q.size() > 0) begin
         e = exp_dma_q.pop_front(); g = got_dma_q.pop_front();
         checks++; if (g !== e) begin failures++; $display("FAIL cw_sb_data got=%h exp=%h", g, e); end
      end
      exp_dma_q.delete(); got_dma_q.delete();
   endtask

   task automatic test_dma_boundary();
      int dv;
      logic [7:0] e, g;
      dv = dma_valid_cnt;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 23'h7FFFFF; dma_bank = 2'd3;
      slot_open();
      checks++; if (sd_addr !== 23'h7FFFFF || sd_bank !== 2'd3 || owner !== 2'd3) begin
         failures++; $display("FAIL dma_max_cmd got=%h/%0d own%0d exp=7fffff/3 own3", sd_addr, sd_bank, owner); end
      dma_req = 1'b0; dma_addr = 23'h0;
      dma_slot_body(8'hC3);
      checks++; if (dma_valid_cnt - dv !== 1) begin failures++; $display("FAIL dma_max_valid got=%0d exp=1", dma_valid_cnt - dv); end
      checks++; if (dma_dout !== 8'hC3) begin failures++; $display("FAIL dma_max_dout got=%h exp=c3", dma_dout); end
      while (exp_dma_q.size() > 0 && got_dma_q.size() > 0) begin
         e = exp_dma_q.pop_front(); g = got_dma_q.pop_front();
         checks++; if (g !== e) begin failures++; $display("FAIL dma_max_sb got=%h exp=%h", g, e); end
      end
      exp_dma_q.delete(); got_dma_q.delete();
   endtask

   task automatic test_back_to_back();
      int dv, da;
      logic [7:0] e, g;
      dv = dma_valid_cnt; da = dma_ack_cnt;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 23'h000010; dma_bank = 2'd2;
      slot_open();
      checks++; if (sd_addr !== 23'h000010) begin failures++; $display("FAIL b2b_addr0 got=%h exp=000010", sd_addr); end
      dma_addr = 23'h000011;
      dma_slot_body(8'h11);
      slot_open();
      checks++; if (sd_addr !== 23'h000011 || dma_ack !== 1'b1) begin
         failures++; $display("FAIL b2b_addr1 got=%h ack%b exp=000011 ack1", sd_addr, dma_ack); end
      dma_req = 1'b0;
      dma_slot_body(8'h22);
      checks++; if (dma_valid_cnt - dv !== 2 || dma_ack_cnt - da !== 2) begin
         failures++; $display("FAIL b2b_counts got=valid%0d ack%0d exp=2/2", dma_valid_cnt - dv, dma_ack_cnt - da); end
      checks++; if (got_dma_q.size() !== 2) begin failures++; $display("FAIL b2b_sb_size got=%0d exp=2", got_dma_q.size()); end
      while (exp_dma_q.size() > 0 && got_dma_q.size() > 0) begin
         e = exp_dma_q.pop_front(); g = got_dma_q.pop_front();
         checks++; if (g !== e) begin failures++; $display("FAIL b2b_sb_data got=%h exp=%h", g, e); end
      end
      exp_dma_q.delete(); got_dma_q.delete();
   endtask

   task automatic test_ld_drop();
      int la;
      la = ld_ack_cnt;
      ld_req = 1'b1; ld_addr = 23'h000777; ld_bank = 2'd2; ld_din = 8'h9B;
      slot_open();
      checks++; if (owner !== 2'd2 || ld_ack !== 1'b1 || sd_we !== 1'b1 || sd_din !== 8'h9B) begin
         failures++; $display("FAIL ld_write got=own%0d ack%b we%b %h exp=own2 ack1 we1 9b", owner, ld_ack, sd_we, sd_din); end
      ld_req = 1'b0;
      wait_neg(9);
      la = ld_ack_cnt;
      ld_req = 1'b1;
      @(negedge clk_sys);
      ld_req = 1'b0;
      slot_open();
      checks++; if (owner !== 2'd0 || sd_we !== 1'b0 || sd_oe !== 1'b0) begin
         failures++; $display("FAIL ld_drop_idle got=own%0d we%b oe%b exp=own0 we0 oe0", owner, sd_we, sd_oe); end
      wait_neg(10);
      checks++; if (ld_ack_cnt !== la || sd_we !== 1'b0) begin
         failures++; $display("FAIL ld_drop_ack got=ack%0d we%b exp=ack0 we0", ld_ack_cnt - la, sd_we); end
   endtask

   task automatic test_reset_mid();
      cpu_rd = 1'b1; cpu_addr = 23'h000321;
      slot_open();
      cpu_rd = 1'b0;
      checks++; if (sd_oe !== 1'b1) begin failures++; $display("FAIL rstmid_pre got=oe%b exp=oe1", sd_oe); end
      wait_neg(2);
      #2 reset = 1'b1;
      #1;
      checks++; if (sd_oe !== 1'b0 || owner !== 2'd0) begin
         failures++; $display("FAIL rstmid_async got=oe%b own%0d exp=oe0 own0", sd_oe, owner); end
      wait_neg(2);
      reset = 1'b0;
      wait_neg(RD_LAT - 5);
      sd_dout = 8'h99;
      wait_neg(1);
      sd_dout = 8'hEE;
      checks++; if (cpu_dout !== 8'hFF) begin failures++; $display("FAIL rstmid_capture got=%h exp=ff", cpu_dout); end
      wait_neg(3);
   endtask

   initial begin
      test_reset();
      test_cpu_read();
      test_hold_rr();
      test_cpu_then_dma();
      test_dma_boundary();
      test_back_to_back();
      test_ld_drop();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
